store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/ooop_defs.sv | 12 +
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ooop_defs.sv
// Shared core definitions: datapath width and memory access sizes.
package ooop_defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

endpackage

// File: rtl/store_buffer.sv
// Store buffer: holds speculative stores, retires them in ROB order and
// drains committed stores to the data memory one write per cycle.
module store_buffer
    import ooop_defs::*;
#(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int XLEN_P = XLEN
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [31:0]         st_addr_i,
    input  logic [XLEN_P-1:0]   st_data_i,
    input  logic [1:0]          st_size_i,
    input  logic [TAG_W-1:0]    st_tag_i,
    output logic                st_misaligned_o,

    input  logic                commit_valid_i,
    input  logic [TAG_W-1:0]    commit_tag_i,
    input  logic                flush_i,

    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [XLEN_P-1:0]   mem_wdata_o,
    output logic [XLEN_P/8-1:0] mem_be_o,
    input  logic                mem_ready_i,

    input  logic [31:0]         ld_addr_i,
    output logic                ld_conflict_o,

    output logic                empty_o,
    output logic                full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BE_W  = XLEN_P / 8;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]      r_head;
    logic [PTR_W:0]      r_cmt;
    logic [PTR_W:0]      r_tail;
    logic                r_misaligned;

    logic [29:0]         r_addr [DEPTH];
    logic [XLEN_P-1:0]   r_data [DEPTH];
    logic [BE_W-1:0]     r_be   [DEPTH];
    logic [TAG_W-1:0]    r_tag  [DEPTH];

    logic [PTR_W-1:0]    w_head_idx;
    logic [PTR_W-1:0]    w_cmt_idx;
    logic [PTR_W-1:0]    w_tail_idx;
    logic [PTR_W:0]      w_count;
    logic [PTR_W:0]      w_cmt_next;
    logic                w_empty;
    logic                w_full;
    logic                w_misaligned;
    logic [BE_W-1:0]     w_be;
    logic [XLEN_P-1:0]   w_wdata;
    logic                w_enq;
    logic                w_commit;
    logic                w_drain;
    logic                w_ld_conflict;
    logic                w_unused_ld;

    assign w_head_idx = r_head[PTR_W-1:0];
    assign w_cmt_idx  = r_cmt[PTR_W-1:0];
    assign w_tail_idx = r_tail[PTR_W-1:0];
    assign w_count    = r_tail - r_head;
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PTR_W] != r_tail[PTR_W]);

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = '0;
        case (st_size_i)
            BYTE:    w_be = BE_W'(1) << st_addr_i[1:0];
            HALF: begin
                w_misaligned = st_addr_i[0];
                w_be         = BE_W'(3) << st_addr_i[1:0];
            end
            WORD: begin
                w_misaligned = |st_addr_i[1:0];
                w_be         = '1;
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_wdata = st_data_i << {st_addr_i[1:0], 3'b000};

    // Ready looks only at pre-edge occupancy; a same-cycle drain does not free a slot.
    assign st_ready_o = !w_full && !flush_i;
    assign w_enq      = st_valid_i && st_ready_o && !w_misaligned;
    assign w_commit   = commit_valid_i && (r_cmt != r_tail) && (r_tag[w_cmt_idx] == commit_tag_i);
    assign w_drain    = mem_we_o && mem_ready_i;
    assign w_cmt_next = r_cmt + {{PTR_W{1'b0}}, w_commit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_cmt        <= '0;
            r_tail       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_head       <= r_head + {{PTR_W{1'b0}}, w_drain};
            r_cmt        <= w_cmt_next;
            r_tail       <= flush_i ? w_cmt_next : r_tail + {{PTR_W{1'b0}}, w_enq};
            r_misaligned <= st_valid_i && st_ready_o && w_misaligned;
        end
    end

    // NOTE: payload arrays are not reset; pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[w_tail_idx] <= st_addr_i[31:2];
            r_data[w_tail_idx] <= w_wdata;
            r_be[w_tail_idx]   <= w_be;
            r_tag[w_tail_idx]  <= st_tag_i;
        end
    end

    always_comb begin : ld_check
        logic [PTR_W-1:0] off;
        w_ld_conflict = 1'b0;
        off           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - w_head_idx;
            if (({1'b0, off} < w_count) && (r_addr[i] == ld_addr_i[31:2])) begin
                w_ld_conflict = 1'b1;
            end
        end
    end

    assign w_unused_ld     = ^ld_addr_i[1:0];

    assign mem_we_o        = (r_head != r_cmt);
    assign mem_addr_o      = {r_addr[w_head_idx], 2'b00};
    assign mem_wdata_o     = r_data[w_head_idx];
    assign mem_be_o        = r_be[w_head_idx];
    assign ld_conflict_o   = w_ld_conflict;
    assign st_misaligned_o = r_misaligned;
    assign empty_o         = w_empty;
    assign full_o          = w_full;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              st_valid_i;
    logic              st_ready_o;
    logic [31:0]       st_addr_i;
    logic [31:0]       st_data_i;
    logic [1:0]        st_size_i;
    logic [TAG_W-1:0]  st_tag_i;
    logic              st_misaligned_o;
    logic              commit_valid_i;
    logic [TAG_W-1:0]  commit_tag_i;
    logic              flush_i;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ready_i;
    logic [31:0]       ld_addr_i;
    logic              ld_conflict_o;
    logic              empty_o;
    logic              full_o;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid_i     (st_valid_i),
        .st_ready_o     (st_ready_o),
        .st_addr_i      (st_addr_i),
        .st_data_i      (st_data_i),
        .st_size_i      (st_size_i),
        .st_tag_i       (st_tag_i),
        .st_misaligned_o(st_misaligned_o),
        .commit_valid_i (commit_valid_i),
        .commit_tag_i   (commit_tag_i),
        .flush_i        (flush_i),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_ready_i    (mem_ready_i),
        .ld_addr_i      (ld_addr_i),
        .ld_conflict_o  (ld_conflict_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    typedef struct {
        logic [29:0]      waddr;
        logic [31:0]      data;
        logic [3:0]       be;
        logic [TAG_W-1:0] tag;
    } ent_t;

    // Model: queue of live stores (oldest first); the first n_cmt are committed.
    ent_t        q[$];
    int          n_cmt;
    logic        exp_mis;
    logic [31:0] obs_writes[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz, input logic [TAG_W-1:0] t);
        ent_t e;
        int   lane;
        lane    = int'(a % 4);
        e.waddr = a[31:2];
        e.data  = d << (8 * lane);
        e.be    = (sz == 2'd0) ? 4'(1 << lane) : (sz == 2'd1) ? 4'(3 << lane) : 4'hF;
        e.tag   = t;
        return e;
    endfunction

    // Compare every output against the model on the falling edge, then advance the model.
    task automatic cycle();
        logic exp_full, exp_ready, exp_we, exp_conf, mis, enq, commit, drain;
        ent_t ne;
        @(negedge clk);
        exp_full  = (q.size() == DEPTH);
        exp_ready = !exp_full && !flush_i;
        exp_we    = (n_cmt > 0);
        exp_conf  = 1'b0;
        foreach (q[i]) if (q[i].waddr == ld_addr_i[31:2]) exp_conf = 1'b1;

        checks++; if (full_o !== exp_full) begin failures++; $display("FAIL model_full got=%b exp=%b t=%0t", full_o, exp_full, $time); end
        checks++; if (empty_o !== (q.size() == 0)) begin failures++; $display("FAIL model_empty got=%b exp=%b t=%0t", empty_o, q.size() == 0, $time); end
        checks++; if (st_ready_o !== exp_ready) begin failures++; $display("FAIL model_ready got=%b exp=%b t=%0t", st_ready_o, exp_ready, $time); end
        checks++; if (mem_we_o !== exp_we) begin failures++; $display("FAIL model_we got=%b exp=%b t=%0t", mem_we_o, exp_we, $time); end
        checks++; if (ld_conflict_o !== exp_conf) begin failures++; $display("FAIL model_conflict got=%b exp=%b t=%0t", ld_conflict_o, exp_conf, $time); end
        checks++; if (st_misaligned_o !== exp_mis) begin failures++; $display("FAIL model_misaligned got=%b exp=%b t=%0t", st_misaligned_o, exp_mis, $time); end
        if (exp_we) begin
            checks++;
            if (mem_addr_o !== {q[0].waddr, 2'b00} || mem_wdata_o !== q[0].data || mem_be_o !== q[0].be) begin
                failures++;
                $display("FAIL model_write got=%h/%h/%b exp=%h/%h/%b t=%0t", mem_addr_o, mem_wdata_o, mem_be_o,
                         {q[0].waddr, 2'b00}, q[0].data, q[0].be, $time);
            end
        end
        if (mem_we_o === 1'b1 && mem_ready_i) obs_writes.push_back(mem_addr_o);

        if (rst) begin
            q.delete();
            n_cmt   = 0;
            exp_mis = 1'b0;
        end else begin
            mis    = is_mis(st_size_i, st_addr_i);
            enq    = st_valid_i && exp_ready && !mis;
            commit = commit_valid_i && (q.size() > n_cmt) && (q[n_cmt].tag == commit_tag_i);
            drain  = exp_we && mem_ready_i;
            ne     = make_ent(st_addr_i, st_data_i, st_size_i, st_tag_i);
            if (drain) begin q.delete(0); n_cmt--; end
            if (commit) n_cmt++;
            if (flush_i) begin
                while (q.size() > n_cmt) q.delete(q.size() - 1);
            end else if (enq) begin
                q.push_back(ne);
            end
            exp_mis = st_valid_i && exp_ready && mis;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid_i     = 1'b0;
        st_addr_i      = '0;
        st_data_i      = '0;
        st_size_i      = 2'd0;
        st_tag_i       = '0;
        commit_valid_i = 1'b0;
        commit_tag_i   = '0;
        flush_i        = 1'b0;
        ld_addr_i      = 32'hFFFF_FFF0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic [TAG_W-1:0] t);
        st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_size_i = sz; st_tag_i = t;
        cycle();
        st_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [TAG_W-1:0] t);
        commit_valid_i = 1'b1; commit_tag_i = t;
        cycle();
        commit_valid_i = 1'b0;
    endtask

    task automatic drain_all();
        mem_ready_i = 1'b1;
        for (int k = 0; k < 4 * DEPTH && empty_o !== 1'b1; k++) cycle();
        mem_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", empty_o); end
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        q.delete(); n_cmt = 0; exp_mis = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
        checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_o); end
        checks++; if (st_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", st_ready_o); end
        checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
        checks++; if (st_misaligned_o !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", st_misaligned_o); end
        checks++; if (ld_conflict_o !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", ld_conflict_o); end
    endtask

    task automatic test_byte_lane();
        push_store(32'h103, 32'hAB, 2'd0, 6'd1);
        do_commit(6'd1);
        checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", mem_we_o); end
        checks++; if (mem_addr_o !== 32'h100) begin failures++; $display("FAIL sb_addr got=%h exp=00000100", mem_addr_o); end
        checks++; if (mem_be_o !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", mem_be_o); end
        checks++; if (mem_wdata_o !== 32'hAB00_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=ab000000", mem_wdata_o); end
        obs_writes.delete();
        drain_all();
        checks++; if (obs_writes.size() != 1) begin failures++; $display("FAIL sb_count got=%0d exp=1", obs_writes.size()); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < DEPTH; i++) push_store(32'h1000 + 32'(4 * i), $urandom, 2'd2, TAG_W'(i));
        st_valid_i = 1'b1; st_addr_i = 32'h2000; st_size_i = 2'd2; st_tag_i = 6'd40;
        #1;
        checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full_o); end
        checks++; if (st_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", st_ready_o); end
        cycle();
        st_valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_commit(TAG_W'(i));
        obs_writes.delete();
        drain_all();
        checks++; if (obs_writes.size() != DEPTH) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", obs_writes.size(), DEPTH); end
        foreach (obs_writes[i]) begin
            checks++;
            if (obs_writes[i] !== 32'h1000 + 32'(4 * i)) begin
                failures++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, obs_writes[i], 32'h1000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush();
        push_store(32'h400, 32'h11, 2'd2, 6'd1);
        push_store(32'h404, 32'h22, 2'd2, 6'd2);
        push_store(32'h408, 32'h33, 2'd2, 6'd3);
        do_commit(6'd1);
        flush_i = 1'b1;
        #1;
        checks++; if (st_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", st_ready_o); end
        do_commit(6'd2);
        flush_i = 1'b0;
        do_commit(6'd3);
        obs_writes.delete();
        drain_all();
        checks++; if (obs_writes.size() != 2) begin failures++; $display("FAIL flush_count got=%0d exp=2", obs_writes.size()); end
        if (obs_writes.size() == 2) begin
            checks++;
            if (obs_writes[0] !== 32'h400 || obs_writes[1] !== 32'h404) begin
                failures++; $display("FAIL flush_order got=%h,%h exp=00000400,00000404", obs_writes[0], obs_writes[1]);
            end
        end
    endtask

    task automatic test_half_misaligned();
        push_store(32'h202, 32'h1234, 2'd1, 6'd5);
        do_commit(6'd5);
        checks++; if (mem_be_o !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", mem_be_o); end
        checks++; if (mem_wdata_o !== 32'h1234_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=12340000", mem_wdata_o); end
        drain_all();
        push_store(32'h206, 32'hDEAD_BEEF, 2'd2, 6'd6);
        checks++; if (st_misaligned_o !== 1'b1) begin failures++; $display("FAIL sw_mis got=%b exp=1", st_misaligned_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL sw_noenq got=%b exp=1", empty_o); end
        cycle();
        checks++; if (st_misaligned_o !== 1'b0) begin failures++; $display("FAIL sw_pulse got=%b exp=0", st_misaligned_o); end
    endtask

    task automatic test_ld_conflict();
        push_store(32'h300, 32'h55, 2'd2, 6'd9);
        ld_addr_i = 32'h302;
        #1;
        checks++; if (ld_conflict_o !== 1'b1) begin failures++; $display("FAIL ld_hit got=%b exp=1", ld_conflict_o); end
        ld_addr_i = 32'h304;
        #1;
        checks++; if (ld_conflict_o !== 1'b0) begin failures++; $display("FAIL ld_neighbour got=%b exp=0", ld_conflict_o); end
        ld_addr_i = 32'h302;
        do_commit(6'd9);
        drain_all();
        checks++; if (ld_conflict_o !== 1'b0) begin failures++; $display("FAIL ld_after_drain got=%b exp=0", ld_conflict_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push_store(32'h500 + 32'(4 * i), $urandom, 2'd2, TAG_W'(10 + i));
        for (int i = 0; i < 3; i++) do_commit(TAG_W'(10 + i));
        ld_addr_i = 32'h500;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", mem_we_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", empty_o); end
        checks++; if (ld_conflict_o !== 1'b0) begin failures++; $display("FAIL rstmid_conflict got=%b exp=0", ld_conflict_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            st_valid_i     = ($urandom % 3) != 0;
            st_addr_i      = 32'h800 + $urandom_range(0, 31);
            st_size_i      = 2'($urandom % 4);
            st_data_i      = $urandom;
            st_tag_i       = TAG_W'($urandom);
            commit_valid_i = ($urandom % 3) != 0;
            commit_tag_i   = ((q.size() > n_cmt) && ($urandom % 4 != 0)) ? q[n_cmt].tag : TAG_W'($urandom);
            flush_i        = ($urandom % 25) == 0;
            mem_ready_i    = ($urandom % 3) != 0;
            ld_addr_i      = 32'h800 + $urandom_range(0, 40);
            cycle();
        end
        idle_inputs();
        drain_all();
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_fill_full();
        test_flush();
        test_half_misaligned();
        test_ld_conflict();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
